// File: rtl/execution_pipe.sv
// Execution stage: ALU or immediate pass-through with valid/ready handshake, flags and flush.
// Define EXECUTION_PIPE_MUL_EN to replace SRA (aluctr=111) with a W-cycle shift-add multiplier.
module execution_pipe #(
  parameter int unsigned W  = 16,
  parameter int unsigned RA = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  rd_data,
  input  logic [W-1:0]  s0,
  input  logic [W-1:0]  im,
  input  logic [2:0]    aluctr,
  input  logic          s2ctr,
  input  logic          we,
  input  logic [RA-1:0] rdest_r,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  s2,
  output logic          we_r,
  output logic [RA-1:0] rdest_rr,
  output logic          zf,
  output logic          cf
);

  localparam int unsigned SW = $clog2(W);

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  s2_q, s2_d;
  logic          we_r_q, we_r_d;
  logic [RA-1:0] rdest_rr_q, rdest_rr_d;
  logic          zf_q, zf_d;
  logic          cf_q, cf_d;

  logic [W-1:0]  alu_res_c;
  logic          alu_cf_c;
  logic [W:0]    sum_c;
  logic [W:0]    diff_c;
  logic [SW-1:0] shamt_c;
  logic [W-1:0]  load_res_c;
  logic          load_cf_c;
  logic          idle_c;
  logic          accept_c;

`ifdef EXECUTION_PIPE_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]  mplier_q, mplier_d;
  logic          mwe_q, mwe_d;
  logic [RA-1:0] mrd_q, mrd_d;
  logic          start_mul_c;

  assign idle_c      = (state_q == S_IDLE);
  assign start_mul_c = (aluctr == 3'b111) && !s2ctr;
`else
  assign idle_c = 1'b1;
`endif

  assign in_ready = idle_c && (!out_valid_q || out_ready) && !flush;
  assign accept_c = in_valid && in_ready;

  // Single-cycle ALU; carry is the (W+1)th sum bit, borrow the (W+1)th difference bit.
  always_comb begin
    alu_res_c = '0;
    alu_cf_c  = 1'b0;
    shamt_c   = s0[SW-1:0];
    sum_c     = {1'b0, rd_data} + {1'b0, s0};
    diff_c    = {1'b0, rd_data} - {1'b0, s0};
    case (aluctr)
      3'b000: begin
        alu_res_c = sum_c[W-1:0];
        alu_cf_c  = sum_c[W];
      end
      3'b001: begin
        alu_res_c = diff_c[W-1:0];
        alu_cf_c  = diff_c[W];
      end
      3'b010: alu_res_c = rd_data & s0;
      3'b011: alu_res_c = rd_data | s0;
      3'b100: alu_res_c = rd_data ^ s0;
      3'b101: alu_res_c = rd_data << shamt_c;
      3'b110: alu_res_c = rd_data >> shamt_c;
`ifndef EXECUTION_PIPE_MUL_EN
      3'b111: alu_res_c = W'($signed(rd_data) >>> shamt_c);
`endif
      default: ;
    endcase
  end

  assign load_res_c = s2ctr ? im : alu_res_c;
  assign load_cf_c  = s2ctr ? 1'b0 : alu_cf_c;

  // Next state: flush wins, then drain/accept, then multiplier progress.
  always_comb begin
    out_valid_d = out_valid_q;
    s2_d        = s2_q;
    we_r_d      = we_r_q;
    rdest_rr_d  = rdest_rr_q;
    zf_d        = zf_q;
    cf_d        = cf_q;
`ifdef EXECUTION_PIPE_MUL_EN
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mwe_d    = mwe_q;
    mrd_d    = mrd_q;
`endif
    if (flush) begin
      out_valid_d = 1'b0;
`ifdef EXECUTION_PIPE_MUL_EN
      state_d = S_IDLE;
`endif
    end else begin
      if (out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept_c) begin
`ifdef EXECUTION_PIPE_MUL_EN
        if (start_mul_c) begin
          mcand_d  = rd_data;
          mplier_d = s0;
          mwe_d    = we;
          mrd_d    = rdest_r;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_MUL;
        end else
`endif
        begin
          out_valid_d = 1'b1;
          s2_d        = load_res_c;
          we_r_d      = we;
          rdest_rr_d  = rdest_r;
          zf_d        = (load_res_c == '0);
          cf_d        = load_cf_c;
        end
      end
`ifdef EXECUTION_PIPE_MUL_EN
      case (state_q)
        S_MUL: begin
          acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + SW'(1);
          if (cnt_q == SW'(W - 1)) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (!out_valid_q || out_ready) begin
            out_valid_d = 1'b1;
            s2_d        = acc_q;
            we_r_d      = mwe_q;
            rdest_rr_d  = mrd_q;
            zf_d        = (acc_q == '0);
            cf_d        = 1'b0;
            state_d     = S_IDLE;
          end
        end
        default: ;
      endcase
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      s2_q        <= '0;
      we_r_q      <= 1'b0;
      rdest_rr_q  <= '0;
      zf_q        <= 1'b0;
      cf_q        <= 1'b0;
`ifdef EXECUTION_PIPE_MUL_EN
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mwe_q    <= 1'b0;
      mrd_q    <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      s2_q        <= s2_d;
      we_r_q      <= we_r_d;
      rdest_rr_q  <= rdest_rr_d;
      zf_q        <= zf_d;
      cf_q        <= cf_d;
`ifdef EXECUTION_PIPE_MUL_EN
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      mwe_q    <= mwe_d;
      mrd_q    <= mrd_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign s2        = s2_q;
  assign we_r      = we_r_q;
  assign rdest_rr  = rdest_rr_q;
  assign zf        = zf_q;
  assign cf        = cf_q;

endmodule

// File: doc/execution_pipe.md
# execution_pipe

Parametrised execution stage for the pipelined CPU core. It sits between decode/register-read and writeback, and computes an ALU result or passes an immediate through. It registers the result together with the destination register index and the write enable. Compared with the fixed 16-bit stage, it adds:

- a valid/ready handshake with stall support;
- a wider operation set with zero/carry flags;
- a synchronous flush;
- an optional multi-cycle iterative multiplier.

## Interface
- W, 16, datapath width (≥ 4, power of 2)
- RA, 4, register-index width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low (rst=0 resets)
- flush  in  1  synchronous kill of in-flight work and output
- in_valid  in  1  upstream presents an operation
- in_ready  out  1  stage accepts this cycle
- rd_data  in  W  operand A
- s0  in  W  operand B
- im  in  W  immediate, already extended upstream
- aluctr  in  3  operation select
- s2ctr  in  1  1 = result is im, 0 = ALU result
- we  in  1  register-write enable to carry forward
- rdest_r  in  RA  destination register index
- out_valid  out  1  s2/we_r/rdest_rr/flags valid
- out_ready  in  1  downstream accepts
- s2  out  W  result
- we_r  out  1  registered we
- rdest_rr  out  RA  registered rdest_r
- zf  out  1  s2 == 0
- cf  out  1  carry (ADD) / borrow (SUB), else 0

## Operation
- **aluctr codes:**
  - 000 ADD, 001 SUB (A−B), 010 AND, 011 OR, 100 XOR.
  - 101 SLL A by B[log2W−1:0]; 110 SRL likewise.
  - 111 SRA, or MUL when the multiplier is configured.
- **Arithmetic:** modulo 2^W. cf = bit W of the (W+1)-bit sum for ADD. For SUB, cf = 1 iff A < B unsigned. MUL gives the low W bits of the unsigned product, with cf = 0.
- **Accept:** in_valid && in_ready at a rising edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- **Output register:** loads on accept of a single-cycle op. Holds its value while out_valid && !out_ready.
- **Immediate path:** s2ctr=1 → s2 = im, single-cycle, never starts MUL. zf reflects im; cf = 0.
- **FSM states:**
  - IDLE: accepts operations. Accepting MUL with s2ctr=0 latches the operands, we and rdest, clears the accumulator and counter, and goes to MUL.
  - MUL: one shift-add step per cycle. After step W it goes to DONE.
  - DONE: loads the output register when !out_valid || out_ready, then returns to IDLE.
- **flush:** clears out_valid and returns the FSM to IDLE. An operation presented in the same cycle is not accepted (in_ready=0). flush has priority over all other events.
- **Simultaneous events:** the output drains (out_ready) in the same edge as a new accept → the new result replaces the old one, and out_valid stays 1.

## Timing
- **Reset** (rst low, asynchronous):
  - out_valid=0, s2=0, we_r=0, rdest_rr=0, zf=0, cf=0.
  - FSM=IDLE, counter=0.
  - in_ready is 1 after release.
- **Reset mid-multiply:** aborts the multiply; no output is produced.
- **Single-cycle op latency:** accept at edge T → outputs valid after edge T. One op per cycle is possible with out_ready held at 1.
- **MUL latency:** accept at edge T → steps at edges T+1…T+W, and the result is loaded at edge T+W+1 if the output is free. in_ready=0 from after T until the FSM returns to IDLE.
- **Output stability:** outputs are only ever driven from flops. s2, we_r, rdest_rr and the flags are stable while out_valid && !out_ready.

## Configuration
- **EXECUTION_PIPE_MUL_EN defined:** aluctr=111 is MUL, and the MUL/DONE states and the W-cycle multiplier are built.
- **Not defined:**
  - aluctr=111 is single-cycle SRA (A >>> B[log2W−1:0]).
  - The FSM is removed; the stage is IDLE permanently.
  - in_ready = (!out_valid || out_ready) && !flush.

## Test plan
- **Reset release:** all outputs are 0 and in_ready=1. Then ADD 0x7FFF+0x0001, rdest=3, we=1 → next cycle s2=0x8000, cf=0, zf=0, rdest_rr=3, we_r=1.
- **SUB and immediate:**
  - SUB 0x0001−0x0002 → s2=0xFFFF, cf=1.
  - s2ctr=1 with im=0x0000 and aluctr=ADD → s2=0x0000, zf=1, cf=0.
- **Back-pressure:** hold out_ready=0 after one result → in_ready=0, outputs are stable for 5 cycles, and the next op is accepted on the edge where out_ready=1.
- **MUL (EXECUTION_PIPE_MUL_EN, W=16):** 0x0123×0x0010 → s2=0x1230 exactly 17 edges after accept, with in_ready=0 throughout.
- **Without the macro:** aluctr=111, A=0x8000, B=4 → s2=0xF800.
- **Abort cases:**
  - Assert flush, or pulse rst low, at step 5 of a MUL → no out_valid, FSM in IDLE, and the next ADD completes normally in 1 cycle.
  - flush asserted while out_valid=1 → out_valid=0 on the next edge.
